// File: rtl/ps2_key_decoder_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 key decoder slice.
//   SC_EXT / SC_BRK  : Set-2 prefix bytes for extended keys and key release.
//   SC_*             : controller/status bytes that carry no key information.
//   fetch_state_e    : states of the FIFO fetch machine.
//   is_ignored()     : true for bytes the decoder drops without touching prefixes.
package ps2_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        GAP
    } fetch_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        case (b)
            SC_PAUSE, SC_BAT_OK, SC_ACK, SC_RESEND, SC_ERR_LO, SC_ERR_HI: hit = 1'b1;
            default:                                                     hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_ascii_lut.sv
// ps2_ascii_lut: combinational Set-2 scancode to ASCII translation.
//   code  : scancode of the key
//   ext   : key was E0-prefixed; extended keys have no ASCII mapping
//   ascii : lowercase letter, digit, space or CR; 0x00 when unmapped
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: ascii = 8'h61; // a
                8'h32: ascii = 8'h62; // b
                8'h21: ascii = 8'h63; // c
                8'h23: ascii = 8'h64; // d
                8'h24: ascii = 8'h65; // e
                8'h2B: ascii = 8'h66; // f
                8'h34: ascii = 8'h67; // g
                8'h33: ascii = 8'h68; // h
                8'h43: ascii = 8'h69; // i
                8'h3B: ascii = 8'h6A; // j
                8'h42: ascii = 8'h6B; // k
                8'h4B: ascii = 8'h6C; // l
                8'h3A: ascii = 8'h6D; // m
                8'h31: ascii = 8'h6E; // n
                8'h44: ascii = 8'h6F; // o
                8'h4D: ascii = 8'h70; // p
                8'h15: ascii = 8'h71; // q
                8'h2D: ascii = 8'h72; // r
                8'h1B: ascii = 8'h73; // s
                8'h2C: ascii = 8'h74; // t
                8'h3C: ascii = 8'h75; // u
                8'h2A: ascii = 8'h76; // v
                8'h1D: ascii = 8'h77; // w
                8'h22: ascii = 8'h78; // x
                8'h35: ascii = 8'h79; // y
                8'h1A: ascii = 8'h7A; // z
                8'h45: ascii = 8'h30; // 0
                8'h16: ascii = 8'h31; // 1
                8'h1E: ascii = 8'h32; // 2
                8'h26: ascii = 8'h33; // 3
                8'h25: ascii = 8'h34; // 4
                8'h2E: ascii = 8'h35; // 5
                8'h36: ascii = 8'h36; // 6
                8'h3D: ascii = 8'h37; // 7
                8'h3E: ascii = 8'h38; // 8
                8'h46: ascii = 8'h39; // 9
                8'h29: ascii = 8'h20; // space
                8'h5A: ascii = 8'h0D; // enter
                default: ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: pops Set-2 scancodes from the PS/2 receiver FIFO and
// tracks the single most recent key.
//   clock, reset          : system clock, synchronous active-high reset
//   kb_data/kb_ready      : FIFO head byte and non-empty flag
//   kb_overflow           : receiver dropped a byte (latched into err_overflow)
//   kb_nextdata_n         : active-low pop strobe, low for the one POP cycle
//   key_valid/code/ext    : held (or last released) key
//   key_ascii             : ASCII of the key, 0x00 when unmapped or extended
//   make/break/repeat_pulse : one-cycle key events
//   press_count           : number of new presses, wrapping
//   err_overflow          : sticky overflow flag
import ps2_pkg::*;

module ps2_key_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       kb_data,
    input  logic             kb_ready,
    input  logic             kb_overflow,
    output logic             kb_nextdata_n,
    output logic             key_valid,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic [7:0]       key_ascii,
    output logic             make_pulse,
    output logic             break_pulse,
    output logic             repeat_pulse,
    output logic [CNT_W-1:0] press_count,
    output logic             err_overflow
);

    fetch_state_e     state_q, state_d;
    logic             key_valid_q, key_valid_d;
    logic [7:0]       key_code_q, key_code_d;
    logic             key_ext_q, key_ext_d;
    logic             brk_p_q, brk_p_d;
    logic             ext_p_q, ext_p_d;
    logic             make_q, make_d;
    logic             break_q, break_d;
    logic             repeat_q, repeat_d;
    logic [CNT_W-1:0] press_count_q, press_count_d;
    logic             err_overflow_q, err_overflow_d;
    logic             same_key;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            key_valid_q    <= 1'b0;
            key_code_q     <= 8'h00;
            key_ext_q      <= 1'b0;
            brk_p_q        <= 1'b0;
            ext_p_q        <= 1'b0;
            make_q         <= 1'b0;
            break_q        <= 1'b0;
            repeat_q       <= 1'b0;
            press_count_q  <= '0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            key_valid_q    <= key_valid_d;
            key_code_q     <= key_code_d;
            key_ext_q      <= key_ext_d;
            brk_p_q        <= brk_p_d;
            ext_p_q        <= ext_p_d;
            make_q         <= make_d;
            break_q        <= break_d;
            repeat_q       <= repeat_d;
            press_count_q  <= press_count_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    // GAP gives the FIFO read pointer a cycle to settle before kb_ready is
    // trusted again, which caps throughput at one byte every three cycles.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (kb_ready) state_d = POP;
            POP:     state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The strobe is decoded from the state register, so a reset landing on
    // the POP edge still pops the FIFO while the byte itself is dropped.
    assign kb_nextdata_n = (state_q != POP);

    assign same_key = key_valid_q && (kb_data == key_code_q) && (ext_p_q == key_ext_q);

    // The byte at the FIFO head is decoded straight away during POP, so its
    // effects land on the same edge that pops it.
    always_comb begin
        key_valid_d    = key_valid_q;
        key_code_d     = key_code_q;
        key_ext_d      = key_ext_q;
        brk_p_d        = brk_p_q;
        ext_p_d        = ext_p_q;
        make_d         = 1'b0;
        break_d        = 1'b0;
        repeat_d       = 1'b0;
        press_count_d  = press_count_q;
        err_overflow_d = err_overflow_q | kb_overflow;

        if (state_q == POP) begin
            if (kb_data == SC_EXT) begin
                ext_p_d = 1'b1;
            end else if (kb_data == SC_BRK) begin
                brk_p_d = 1'b1;
            end else if (!is_ignored(kb_data)) begin
                if (brk_p_q) begin
                    // Releases of keys other than the tracked one are dropped.
                    if (same_key) begin
                        key_valid_d = 1'b0;
                        break_d     = 1'b1;
                    end
                end else if (same_key) begin
                    repeat_d = 1'b1;
                end else begin
                    key_code_d    = kb_data;
                    key_ext_d     = ext_p_q;
                    key_valid_d   = 1'b1;
                    make_d        = 1'b1;
                    press_count_d = press_count_q + CNT_W'(1);
                end
                brk_p_d = 1'b0;
                ext_p_d = 1'b0;
            end
        end
    end

    ps2_ascii_lut u_ascii_lut (
        .code  (key_code_q),
        .ext   (key_ext_q),
        .ascii (key_ascii)
    );

    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign make_pulse   = make_q;
    assign break_pulse  = break_q;
    assign repeat_pulse = repeat_q;
    assign press_count  = press_count_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: drives ps2_key_decoder from a modelled receiver FIFO and
// scores every key event against a reference model of the key tracker.
module tb_ps2_key_decoder;

    typedef struct {
        int         kind;   // 0 make, 1 break, 2 repeat
        logic       valid;
        logic [7:0] code;
        logic       ext;
        logic [7:0] ascii;
        logic [7:0] count;
    } expect_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       kb_nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic       make_pulse;
    logic       break_pulse;
    logic       repeat_pulse;
    logic [7:0] press_count;
    logic       err_overflow;

    int total = 0;
    int bad = 0;
    int cycle = 0;
    int make_seen = 0;
    int break_seen = 0;
    int repeat_seen = 0;
    int pop_count = 0;

    logic [7:0] fifo_q[$];
    expect_t    exp_q[$];

    // reference key tracker state
    logic       m_valid = 1'b0;
    logic [7:0] m_code = 8'h00;
    logic       m_ext = 1'b0;
    logic [7:0] m_count = 8'h00;
    logic       m_brk = 1'b0;
    logic       m_extp = 1'b0;

    bit check_gap = 1'b0;
    int prev_pop_cycle = -1;
    int prev_left = 0;

    ps2_key_decoder #(.CNT_W(8)) dut (
        .clock         (clock),
        .reset         (reset),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .key_ext       (key_ext),
        .key_ascii     (key_ascii),
        .make_pulse    (make_pulse),
        .break_pulse   (break_pulse),
        .repeat_pulse  (repeat_pulse),
        .press_count   (press_count),
        .err_overflow  (err_overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ASCII table written as ordered key lists rather than a case table.
    function automatic logic [7:0] refAscii(input logic [7:0] code, input logic ext);
        logic [7:0] letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] digits[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        if (ext) return 8'h00;
        for (int i = 0; i < 26; i++) if (letters[i] == code) return 8'(8'h61 + i);
        for (int i = 0; i < 10; i++) if (digits[i] == code) return 8'(8'h30 + i);
        if (code == 8'h29) return 8'h20;
        if (code == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic pushExpect(input int kind);
        expect_t e;
        e.kind  = kind;
        e.valid = m_valid;
        e.code  = m_code;
        e.ext   = m_ext;
        e.ascii = refAscii(m_code, m_ext);
        e.count = m_count;
        exp_q.push_back(e);
    endtask

    task automatic modelByte(input logic [7:0] b);
        bit same;
        if (b == 8'hE0) begin
            m_extp = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
            // status bytes: nothing changes
        end else begin
            same = m_valid && (b == m_code) && (m_extp == m_ext);
            if (m_brk) begin
                if (same) begin
                    m_valid = 1'b0;
                    pushExpect(1);
                end
            end else if (same) begin
                pushExpect(2);
            end else begin
                m_code  = b;
                m_ext   = m_extp;
                m_valid = 1'b1;
                m_count = m_count + 8'd1;
                pushExpect(0);
            end
            m_brk  = 1'b0;
            m_extp = 1'b0;
        end
    endtask

    task automatic modelReset();
        m_valid = 1'b0;
        m_code  = 8'h00;
        m_ext   = 1'b0;
        m_count = 8'h00;
        m_brk   = 1'b0;
        m_extp  = 1'b0;
        prev_pop_cycle = -1;
    endtask

    // Receiver FIFO model: a strobe seen low during a cycle pops the head at
    // the following edge; the popped byte feeds the model unless reset was up.
    initial begin
        logic pop_pending;
        logic rst_pending;
        logic [7:0] b;
        forever begin
            @(negedge clock);
            pop_pending = (kb_nextdata_n === 1'b0);
            rst_pending = reset;
            @(posedge clock);
            #1;
            if (pop_pending) begin
                pop_count++;
                checkOutput("pop_with_data", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) begin
                    b = fifo_q.pop_front();
                    if (!rst_pending) modelByte(b);
                    if (check_gap && prev_pop_cycle >= 0 && prev_left > 0)
                        checkOutput("pop_spacing", 32'(cycle - prev_pop_cycle), 32'd3);
                    prev_pop_cycle = cycle;
                    prev_left = fifo_q.size();
                end
            end
            if (rst_pending) modelReset();
            #1;
            kb_ready = (fifo_q.size() > 0);
            kb_data  = kb_ready ? fifo_q[0] : 8'h00;
        end
    end

    // Monitor: every event pulse pops one expected event from the scoreboard.
    initial begin
        logic [2:0] pulses;
        logic [2:0] prev_pulses = 3'b000;
        expect_t e;
        int kind;
        forever begin
            @(negedge clock);
            pulses = {make_pulse, break_pulse, repeat_pulse};
            if (pulses != 3'b000 && pulses !== 3'bxxx) begin
                checkOutput("one_pulse_at_a_time", 32'($countones(pulses)), 32'd1);
                checkOutput("pulse_one_cycle", 32'(prev_pulses != 3'b000), 32'd0);
                kind = make_pulse ? 0 : (break_pulse ? 1 : 2);
                if (make_pulse)   make_seen++;
                if (break_pulse)  break_seen++;
                if (repeat_pulse) repeat_seen++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_event", 32'(kind), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("event_kind", 32'(kind), 32'(e.kind));
                    checkOutput("event_key_valid", 32'(key_valid), 32'(e.valid));
                    checkOutput("event_key_code", 32'(key_code), 32'(e.code));
                    checkOutput("event_key_ext", 32'(key_ext), 32'(e.ext));
                    checkOutput("event_key_ascii", 32'(key_ascii), 32'(e.ascii));
                    checkOutput("event_press_count", 32'(press_count), 32'(e.count));
                end
            end
            prev_pulses = (pulses === 3'bxxx) ? 3'b000 : pulses;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] seq[$]);
        foreach (seq[i]) fifo_q.push_back(seq[i]);
    endtask

    // Bounded wait for the FIFO to empty and the decoder to go quiet.
    task automatic drainFifo(input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 4 && n < budget) begin
            tick();
            n++;
            if (fifo_q.size() == 0 && kb_nextdata_n) quiet++;
            else quiet = 0;
        end
        checkOutput("drain_in_budget", 32'(quiet >= 4), 32'd1);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkKeyState(input string tag);
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'(m_valid));
        checkOutput({tag, "_key_code"}, 32'(key_code), 32'(m_code));
        checkOutput({tag, "_key_ext"}, 32'(key_ext), 32'(m_ext));
        checkOutput({tag, "_key_ascii"}, 32'(key_ascii), 32'(refAscii(m_code, m_ext)));
        checkOutput({tag, "_press_count"}, 32'(press_count), 32'(m_count));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_nextdata_n"}, 32'(kb_nextdata_n), 32'd1);
        checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        checkOutput({tag, "_key_code"}, 32'(key_code), 32'h00);
        checkOutput({tag, "_key_ext"}, 32'(key_ext), 32'd0);
        checkOutput({tag, "_key_ascii"}, 32'(key_ascii), 32'h00);
        checkOutput({tag, "_pulses"}, 32'({make_pulse, break_pulse, repeat_pulse}), 32'd0);
        checkOutput({tag, "_press_count"}, 32'(press_count), 32'd0);
        checkOutput({tag, "_err_overflow"}, 32'(err_overflow), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] seq[$];
        logic [7:0] pool[20] = '{8'h1C, 8'h1C, 8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h75,
                                 8'h6B, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'hFA, 8'h00,
                                 8'hFF, 8'hE1};
        int m0, b0, r0, p0;
        int waited;

        $display("[TB] starting ps2_key_decoder bench");
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkResetState("after_reset");

        // press and release 'a'
        m0 = make_seen; b0 = break_seen;
        seq = '{8'h1C, 8'hF0, 8'h1C};
        applyStimulus(seq);
        drainFifo(200);
        checkOutput("a_makes", 32'(make_seen - m0), 32'd1);
        checkOutput("a_breaks", 32'(break_seen - b0), 32'd1);
        checkOutput("a_released", 32'(key_valid), 32'd0);
        checkOutput("a_count", 32'(press_count), 32'd1);
        checkOutput("a_ascii", 32'(key_ascii), 32'h61);
        checkKeyState("a");

        // typematic repeat then release
        m0 = make_seen; b0 = break_seen; r0 = repeat_seen;
        seq = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        applyStimulus(seq);
        drainFifo(200);
        checkOutput("typ_makes", 32'(make_seen - m0), 32'd1);
        checkOutput("typ_repeats", 32'(repeat_seen - r0), 32'd3);
        checkOutput("typ_breaks", 32'(break_seen - b0), 32'd1);
        checkOutput("typ_count", 32'(press_count), 32'd2);

        // extended key: right-hand cursor up
        seq = '{8'hE0, 8'h75};
        applyStimulus(seq);
        drainFifo(200);
        checkOutput("ext_valid", 32'(key_valid), 32'd1);
        checkOutput("ext_flag", 32'(key_ext), 32'd1);
        checkOutput("ext_code", 32'(key_code), 32'h75);
        checkOutput("ext_ascii", 32'(key_ascii), 32'h00);
        seq = '{8'hE0, 8'hF0, 8'h75};
        applyStimulus(seq);
        drainFifo(200);
        checkOutput("ext_released", 32'(key_valid), 32'd0);
        checkKeyState("ext");

        // overflow latches and survives further traffic
        kb_overflow = 1'b1;
        tick();
        kb_overflow = 1'b0;
        seq = '{8'h16};
        applyStimulus(seq);
        drainFifo(200);
        checkOutput("overflow_set", 32'(err_overflow), 32'd1);
        repeat (5) tick();
        checkOutput("overflow_sticky", 32'(err_overflow), 32'd1);
        checkKeyState("after_overflow");

        // reset landing on the POP edge: byte consumed and discarded
        p0 = pop_count;
        seq = '{8'h32};
        applyStimulus(seq);
        waited = 0;
        while (kb_nextdata_n !== 1'b0 && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("reached_pop", 32'(kb_nextdata_n), 32'd0);
        reset = 1'b1;
        tick();
        checkResetState("mid_pop_reset");
        reset = 1'b0;
        tick();
        checkOutput("mid_pop_byte_popped", 32'(pop_count - p0), 32'd1);
        checkOutput("mid_pop_fifo_empty", 32'(fifo_q.size()), 32'd0);
        checkResetState("post_reset");

        // 256 press/release pairs wrap the counter; drain runs at full rate
        m0 = make_seen; b0 = break_seen; p0 = pop_count;
        seq.delete();
        for (int i = 0; i < 256; i++) begin
            seq.push_back(8'h1C);
            seq.push_back(8'hF0);
            seq.push_back(8'h1C);
        end
        check_gap = 1'b1;
        applyStimulus(seq);
        drainFifo(3000);
        check_gap = 1'b0;
        checkOutput("wrap_makes", 32'(make_seen - m0), 32'd256);
        checkOutput("wrap_breaks", 32'(break_seen - b0), 32'd256);
        checkOutput("wrap_pops", 32'(pop_count - p0), 32'd768);
        checkOutput("wrap_count", 32'(press_count), 32'd0);

        // random byte stream from a pool rich in repeats and prefixes
        seq.delete();
        for (int i = 0; i < 400; i++) seq.push_back(pool[$urandom_range(0, 19)]);
        applyStimulus(seq);
        drainFifo(2000);
        checkKeyState("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the scancode byte stream from the PS/2 receiver FIFO (`ps2_keyboard`: `data`/`ready`/`nextdata_n`/`overflow`) and turns Set-2 scancodes into key state. Outputs are the current key, its ASCII value, make/break event pulses and a press counter, for the seven-segment and LED logic. It is the stage directly downstream of the keyboard receiver, in the same single clock domain as the VGA path.

## Interface
Parameters:
- `CNT_W`, default 8: width of the press counter.

Ports:
- `clock`  in  1: system clock. One clock, shared with the receiver.
- `reset`  in  1: synchronous, active-high.
- `kb_data`  in  8: byte at the FIFO head. Valid while `kb_ready`=1.
- `kb_ready`  in  1: FIFO non-empty.
- `kb_overflow`  in  1: the receiver FIFO dropped a byte.
- `kb_nextdata_n`  out  1: active-low pop strobe. Low for exactly one cycle per byte consumed.
- `key_valid`  out  1: a key is currently held.
- `key_code`  out  8: scancode of the held or last-released key.
- `key_ext`  out  1: that key was E0-prefixed.
- `key_ascii`  out  8: ASCII of `key_code`. 0x00 if unmapped or `key_ext`=1.
- `make_pulse`  out  1: one-cycle pulse on a new press.
- `break_pulse`  out  1: one-cycle pulse on release of the held key.
- `repeat_pulse`  out  1: one-cycle pulse on a typematic repeat.
- `press_count`  out  CNT_W: count of new presses. Wraps at 2^CNT_W.
- `err_overflow`  out  1: sticky; set by `kb_overflow`.

## Operation
- Fetch FSM:
  - IDLE: if `kb_ready`=1, go to POP.
  - POP: `kb_nextdata_n`=0; capture `kb_data` at the closing edge; go to GAP.
  - GAP: one dead cycle so the FIFO pointer settles; go to IDLE.
- Decode of each captured byte b, using prefix flags `brk_p` and `ext_p`:
  - b=0xE0: set `ext_p`.
  - b=0xF0: set `brk_p`.
  - b=0xE1, 0xAA, 0xFA, 0xFE, 0x00 or 0xFF: ignored. Prefix flags are unchanged.
  - Any other b with `brk_p`=1 (break):
    - If `key_valid` and b==`key_code` and `ext_p`==`key_ext`: clear `key_valid` and pulse `break_pulse`.
    - Otherwise: no output change.
  - Any other b with `brk_p`=0 (make):
    - If `key_valid` and b==`key_code` and `ext_p`==`key_ext`: pulse `repeat_pulse`. Count unchanged.
    - Otherwise: load `key_code`=b and `key_ext`=`ext_p`, set `key_valid`, increment `press_count`, pulse `make_pulse`.
  - Both prefix flags clear after any non-prefix, non-ignored byte.
- Only one key is tracked. A new make replaces the held key. A break for a non-held key is a no-op.
- `kb_overflow`=1 in any cycle sets `err_overflow`. Only reset clears it.
- `key_ascii` comes from `key_code`/`key_ext` through a LUT:
  - Letters map to lowercase, e.g. 0x1C→0x61 'a', 0x32→0x62 'b'.
  - Digits, e.g. 0x45→0x30, 0x16→0x31.
  - 0x29→0x20 (space), 0x5A→0x0D (Enter).
  - Everything else maps to 0x00.

## Timing
- Reset values:
  - FSM in IDLE, `kb_nextdata_n`=1.
  - `key_valid`=0, `key_code`=0x00, `key_ext`=0, `key_ascii`=0x00.
  - All pulses 0, `press_count`=0, `err_overflow`=0, prefix flags 0.
- `kb_ready` sampled high at edge k: `kb_nextdata_n` is low during cycle k..k+1, the byte is captured at edge k+1, and decoded outputs and pulses are visible from edge k+1 (one cycle after POP).
- Throughput: one byte per 3 cycles.
- Pulses last exactly one cycle. At most one pulse per captured byte.
- `press_count` wraps 2^CNT_W−1 → 0 with no flag.
- `kb_ready` dropping during GAP is legal; the FSM returns to IDLE.
- Reset asserted during POP: the FIFO still pops at that edge, and the byte is discarded. After reset all state is at its reset values.
- `kb_overflow` and a byte decode in the same cycle: both take effect.
- `key_ascii` is combinational from registered `key_code`/`key_ext`, so it has no extra latency.

## Structure
- Shared package `ps2_pkg`:
  - Constants `SC_EXT`=0xE0, `SC_BRK`=0xF0 and the ignored-byte set.
  - FSM state enum {IDLE, POP, GAP}.
- Sub-module `ps2_ascii_lut`: purely combinational. Inputs code[7:0] and ext; output ascii[7:0].

## Test plan
- Bytes 1C, F0, 1C: `make_pulse` once with `key_code`=0x1C and `key_ascii`=0x61. Then `break_pulse`, `key_valid`=0, `press_count`=1.
- Bytes 1C ×4 (typematic), then F0 1C: exactly 1 make, 3 `repeat_pulse`, 1 break. `press_count`=1.
- Bytes E0 75, E0 F0 75: `key_ext`=1, `key_code`=0x75, `key_ascii`=0x00. The break clears `key_valid`.
- 256 make/break pairs with CNT_W=8: `press_count` returns to 0. The FIFO drain shows `kb_nextdata_n` low once every 3 cycles while `kb_ready` is held.
- Pulse `kb_overflow` once: `err_overflow`=1 and stays 1. Assert reset mid-POP: all outputs return to reset values on the next edge.
